change_txn_controller: RTL and testbench
========================================

Name: change_txn_controller

Overview:
- Sequential transaction controller for the change-making datapath. Owns the coin inventory: pentagon = 5, triangle = 3, circle = 1, each count 0..3.
- Collects inserted coins against a latched cost, then computes a greedy change plan from the inventory. It either dispenses the plan one coin at a time over a valid/ready handshake or flags exact payment or insufficient change.
- Sits between the coin-slot front end and the coin-dispenser actuator.

Parameters:
INIT_PENT, 2, pentagon inventory count at reset (0..3)
INIT_TRI, 2, triangle inventory count at reset (0..3)
INIT_CIR, 2, circle inventory count at reset (0..3)

Ports:
clock  input  1  system clock, rising edge
reset_L  input  1  asynchronous active-low reset
start  input  1  begin transaction (honoured in IDLE only)
cost  input  4  item cost, latched on accepted start
coin_valid  input  1  one inserted coin presented this cycle
coin  input  3  coin code: 001 circle, 011 triangle, 101 pentagon; all other codes illegal
pay_done  input  1  customer finished inserting coins
restock_valid  input  1  add one coin to inventory (IDLE only)
restock_coin  input  3  coin code for restock
disp_ready  input  1  dispenser accepts disp_coin
disp_valid  output  1  change coin offered to dispenser
disp_coin  output  3  coin code offered; 000 when disp_valid = 0
coin_accept  output  1  one-cycle pulse: previous cycle's coin accepted
coin_reject  output  1  one-cycle pulse: previous cycle's coin rejected
paid  output  4  running paid total
cough_up_more  output  1  paid < cost, asserted in COLLECT only
exact_amount  output  1  sticky result: paid == cost
not_enough_change  output  1  sticky result: change cannot be made
txn_done  output  1  one-cycle pulse in DONE
busy  output  1  state != IDLE
pent_cnt, tri_cnt, cir_cnt  output  2 each  current inventory

Behaviour:
- Clocking and reset: all state updates on the rising clock edge. Asynchronous reset_L low forces state IDLE, all outputs 0, and inventory to INIT_*. A reset mid-transaction abandons it; no coin is dispensed after reset.
- States: IDLE, COLLECT, PLAN, DISPENSE, DONE.
- IDLE:
  - start=1 latches cost, clears paid, clears exact_amount and not_enough_change, and goes to COLLECT.
  - restock_valid with a legal code increments that count, saturating at 3. Restocks are ignored in all other states.
  - start is ignored outside IDLE.
- COLLECT, coin handling: coin_valid with a legal code is accepted iff its count < 3 and paid + value <= 15.
  - Accept: paid += value and count += 1 in that cycle's update; coin_accept pulses the following cycle.
  - Otherwise (including illegal code): coin_reject pulses the following cycle, and nothing else changes.
- COLLECT, pay_done: evaluated on paid including any coin accepted in the same cycle. If that paid >= cost, go to PLAN. Otherwise pay_done is ignored and the controller stays in COLLECT.
- cough_up_more = (paid < cost) while in COLLECT; 0 in all other states.
- PLAN (exactly 1 cycle), change = paid - cost (4-bit, never negative):
  - change == 0: set exact_amount, go to DONE.
  - Otherwise compute the greedy plan: np = min(pent_cnt, change/5); r1 = change - 5*np; nt = min(tri_cnt, r1/3); r2 = r1 - 3*nt; nc = min(cir_cnt, r2); rem = r2 - nc. Greedy is mandated even where a non-greedy solution exists.
  - rem != 0: set not_enough_change, go to DONE with inventory unchanged. Inserted coins are kept.
  - rem == 0: load plan counters, go to DISPENSE.
- DISPENSE:
  - disp_valid = 1; disp_coin = highest-value coin with a nonzero plan count.
  - On disp_valid & disp_ready: decrement that plan count and its inventory count.
  - disp_coin is held stable while disp_ready = 0.
  - After the final handshake, go to DONE; no bubble between consecutive coins.
- DONE: txn_done = 1 for one cycle, then IDLE. exact_amount and not_enough_change hold until the next accepted start.
- Latency:
  - start to COLLECT: 1 cycle.
  - pay_done to PLAN: 1 cycle.
  - PLAN to first disp_valid: 1 cycle.

Test Plan:
- Defaults 2/2/2: start cost=7; insert 101, then 011; pay_done -> paid=8, one disp_coin=001 handshake, txn_done; counts P=3, T=3, C=1.
- Defaults: cost=8; insert 101, 011; pay_done -> exact_amount=1, disp_valid never asserted, txn_done; exact_amount stays 1 until next start.
- INIT_CIR=0: cost=1; insert 101 -> change 4, plan np=0, nt=1, rem=1 -> not_enough_change=1, no dispense, counts P=3, T=2, C=0.
- Defaults: cost=2; insert 101, 011 -> change 6 -> dispense 101 then 001. Hold disp_ready=0 for 3 cycles on the first coin -> disp_coin stays 101, and counts are unchanged until the handshake.
- Defaults: cost=9; insert 011; pay_done -> stays COLLECT, cough_up_more=1. Insert 101 twice -> second coin rejected (P full), coin_reject pulse, paid=8. Insert 001 -> paid=9; pay_done -> exact_amount.
- Mid-DISPENSE with the first coin pending: drive reset_L=0 -> immediately IDLE, disp_valid=0, counts = INIT_*; restock 011 in IDLE -> tri_cnt=3; restock while busy is ignored.

Source files
------------

// File: rtl/change_txn_controller.sv
// Change-making transaction controller: collects coins against a latched
// cost, plans greedy change from the 5/3/1 coin inventory, then dispenses
// it one coin per valid/ready handshake or flags exact/insufficient change.
module change_txn_controller #(
    parameter logic [1:0] INIT_PENT = 2'd2,
    parameter logic [1:0] INIT_TRI  = 2'd2,
    parameter logic [1:0] INIT_CIR  = 2'd2
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       start,
    input  logic [3:0] cost,
    input  logic       coin_valid,
    input  logic [2:0] coin,
    input  logic       pay_done,
    input  logic       restock_valid,
    input  logic [2:0] restock_coin,
    input  logic       disp_ready,
    output logic       disp_valid,
    output logic [2:0] disp_coin,
    output logic       coin_accept,
    output logic       coin_reject,
    output logic [3:0] paid,
    output logic       cough_up_more,
    output logic       exact_amount,
    output logic       not_enough_change,
    output logic       txn_done,
    output logic       busy,
    output logic [1:0] pent_cnt,
    output logic [1:0] tri_cnt,
    output logic [1:0] cir_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COLLECT  = 3'd1;
    localparam logic [2:0] S_PLAN     = 3'd2;
    localparam logic [2:0] S_DISPENSE = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [2:0] C_CIR  = 3'b001;
    localparam logic [2:0] C_TRI  = 3'b011;
    localparam logic [2:0] C_PENT = 3'b101;

    logic [2:0] state;
    logic [3:0] cost_q, paid_q;
    logic [1:0] pent_q, tri_q, cir_q;
    logic [1:0] np_q, nt_q, nc_q;
    logic       exact_q, nec_q, accept_q, reject_q;

    logic       coin_legal;
    logic [3:0] coin_val;
    logic [1:0] coin_cnt;
    logic [4:0] paid_sum;
    logic       accept;
    logic [3:0] paid_eff;

    logic [3:0] change, q5, r1, q3, r2, rem;
    logic [1:0] np_c, nt_c, nc_c;
    logic       last_coin;

    // Decode the inserted coin and decide acceptance against inventory and paid limit
    always_comb begin
        coin_legal = 1'b1;
        coin_val   = '0;
        coin_cnt   = '0;
        case (coin)
            C_CIR:   begin coin_val = 4'd1; coin_cnt = cir_q;  end
            C_TRI:   begin coin_val = 4'd3; coin_cnt = tri_q;  end
            C_PENT:  begin coin_val = 4'd5; coin_cnt = pent_q; end
            default: coin_legal = 1'b0;
        endcase
        paid_sum = {1'b0, paid_q} + {1'b0, coin_val};
        accept   = (state == S_COLLECT) && coin_valid && coin_legal &&
                   (coin_cnt != 2'd3) && (paid_sum <= 5'd15);
        paid_eff = accept ? paid_sum[3:0] : paid_q;
    end

    // Greedy change plan: largest coin first, each limited by what is in stock
    always_comb begin
        change = paid_q - cost_q;
        q5     = change / 4'd5;
        np_c   = (q5 > {2'b00, pent_q}) ? pent_q : q5[1:0];
        r1     = change - ({2'b00, np_c} * 4'd5);
        q3     = r1 / 4'd3;
        nt_c   = (q3 > {2'b00, tri_q}) ? tri_q : q3[1:0];
        r2     = r1 - ({2'b00, nt_c} * 4'd3);
        nc_c   = (r2 > {2'b00, cir_q}) ? cir_q : r2[1:0];
        rem    = r2 - {2'b00, nc_c};
    end

    // Dispense the highest-value planned coin; flag the final one
    always_comb begin
        disp_valid = (state == S_DISPENSE);
        disp_coin  = '0;
        if (disp_valid) begin
            if (np_q != 2'd0)      disp_coin = C_PENT;
            else if (nt_q != 2'd0) disp_coin = C_TRI;
            else                   disp_coin = C_CIR;
        end
        last_coin = ({2'b00, np_q} + {2'b00, nt_q} + {2'b00, nc_q}) == 4'd1;
    end

    // Transaction state machine, inventory, plan counters and result flags
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state    <= S_IDLE;
            cost_q   <= '0;
            paid_q   <= '0;
            pent_q   <= INIT_PENT;
            tri_q    <= INIT_TRI;
            cir_q    <= INIT_CIR;
            np_q     <= '0;
            nt_q     <= '0;
            nc_q     <= '0;
            exact_q  <= 1'b0;
            nec_q    <= 1'b0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (restock_valid) begin
                        case (restock_coin)
                            C_PENT:  if (pent_q != 2'd3) pent_q <= pent_q + 2'd1;
                            C_TRI:   if (tri_q  != 2'd3) tri_q  <= tri_q  + 2'd1;
                            C_CIR:   if (cir_q  != 2'd3) cir_q  <= cir_q  + 2'd1;
                            default: ;
                        endcase
                    end
                    if (start) begin
                        cost_q  <= cost;
                        paid_q  <= '0;
                        exact_q <= 1'b0;
                        nec_q   <= 1'b0;
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (coin_valid) begin
                        if (accept) begin
                            paid_q   <= paid_sum[3:0];
                            accept_q <= 1'b1;
                            case (coin)
                                C_PENT:  pent_q <= pent_q + 2'd1;
                                C_TRI:   tri_q  <= tri_q  + 2'd1;
                                default: cir_q  <= cir_q  + 2'd1;
                            endcase
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                    if (pay_done && (paid_eff >= cost_q)) state <= S_PLAN;
                end
                S_PLAN: begin
                    if (change == 4'd0) begin
                        exact_q <= 1'b1;
                        state   <= S_DONE;
                    end else if (rem != 4'd0) begin
                        nec_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        np_q  <= np_c;
                        nt_q  <= nt_c;
                        nc_q  <= nc_c;
                        state <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (disp_ready) begin
                        if (np_q != 2'd0) begin
                            np_q   <= np_q - 2'd1;
                            pent_q <= pent_q - 2'd1;
                        end else if (nt_q != 2'd0) begin
                            nt_q  <= nt_q - 2'd1;
                            tri_q <= tri_q - 2'd1;
                        end else begin
                            nc_q  <= nc_q - 2'd1;
                            cir_q <= cir_q - 2'd1;
                        end
                        if (last_coin) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign coin_accept       = accept_q;
    assign coin_reject       = reject_q;
    assign paid              = paid_q;
    assign cough_up_more     = (state == S_COLLECT) && (paid_q < cost_q);
    assign exact_amount      = exact_q;
    assign not_enough_change = nec_q;
    assign txn_done          = (state == S_DONE);
    assign busy              = (state != S_IDLE);
    assign pent_cnt          = pent_q;
    assign tri_cnt           = tri_q;
    assign cir_cnt           = cir_q;

endmodule

// File: tb/tb_change_txn_controller.sv
// Self-checking bench for change_txn_controller: directed scenarios followed
// by randomized transactions, checked against a behavioural coin/plan model.
module tb_change_txn_controller;

    localparam logic [1:0] P0 = 2'd2;
    localparam logic [1:0] T0 = 2'd2;
    localparam logic [1:0] C0 = 2'd2;

    logic       clock = 1'b0;
    logic       reset_L, start, coin_valid, pay_done, restock_valid, disp_ready;
    logic [3:0] cost;
    logic [2:0] coin, restock_coin;
    logic       disp_valid, coin_accept, coin_reject, cough_up_more;
    logic       exact_amount, not_enough_change, txn_done, busy;
    logic [2:0] disp_coin;
    logic [3:0] paid;
    logic [1:0] pent_cnt, tri_cnt, cir_cnt;

    change_txn_controller #(.INIT_PENT(P0), .INIT_TRI(T0), .INIT_CIR(C0)) dut (
        .clock(clock), .reset_L(reset_L), .start(start), .cost(cost),
        .coin_valid(coin_valid), .coin(coin), .pay_done(pay_done),
        .restock_valid(restock_valid), .restock_coin(restock_coin),
        .disp_ready(disp_ready), .disp_valid(disp_valid), .disp_coin(disp_coin),
        .coin_accept(coin_accept), .coin_reject(coin_reject), .paid(paid),
        .cough_up_more(cough_up_more), .exact_amount(exact_amount),
        .not_enough_change(not_enough_change), .txn_done(txn_done), .busy(busy),
        .pent_cnt(pent_cnt), .tri_cnt(tri_cnt), .cir_cnt(cir_cnt)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Behavioural model: inventory indexed 0=pentagon(5), 1=triangle(3), 2=circle(1)
    int inv[3];
    int m_paid, m_cost;
    bit m_exact, m_nec, m_busy;
    logic [2:0] plan_q[$];

    function automatic int idx_of(input logic [2:0] c);
        case (c)
            3'b101:  return 0;
            3'b011:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int val_idx(input int i);
        return (i == 0) ? 5 : (i == 1) ? 3 : 1;
    endfunction

    function automatic logic [2:0] code_idx(input int i);
        return (i == 0) ? 3'b101 : (i == 1) ? 3'b011 : 3'b001;
    endfunction

    function automatic logic [2:0] rand_code();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0, 1:    return 3'b001;
            2, 3:    return 3'b011;
            4, 5:    return 3'b101;
            6:       return 3'b010;
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".pent"}, pent_cnt, inv[0]);
        chk({tag, ".tri"},  tri_cnt,  inv[1]);
        chk({tag, ".cir"},  cir_cnt,  inv[2]);
    endtask

    task automatic do_reset();
        inv[0] = P0; inv[1] = T0; inv[2] = C0;
        m_busy = 0; m_exact = 0; m_nec = 0; m_paid = 0;
        plan_q.delete();
        reset_L = 1'b0;
        start = 0; coin_valid = 0; pay_done = 0; restock_valid = 0; disp_ready = 0;
        cost = '0; coin = '0; restock_coin = '0;
        #2;
        chk("rst.busy", busy, 0);
        chk("rst.disp_valid", disp_valid, 0);
        chk("rst.disp_coin", disp_coin, 0);
        chk("rst.txn_done", txn_done, 0);
        chk("rst.exact", exact_amount, 0);
        chk("rst.nec", not_enough_change, 0);
        chk("rst.paid", paid, 0);
        chk_counts("rst");
        @(posedge clock);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic start_txn(input int c);
        m_cost = c; m_paid = 0; m_exact = 0; m_nec = 0; m_busy = 1;
        start = 1'b1; cost = 4'(c);
        tick();
        start = 1'b0;
        chk("start.busy", busy, 1);
        chk("start.paid", paid, 0);
        chk("start.exact", exact_amount, 0);
        chk("start.nec", not_enough_change, 0);
        chk("start.cough", cough_up_more, (0 < c));
    endtask

    task automatic insert(input logic [2:0] code);
        int i;
        bit acc;
        i = idx_of(code);
        acc = (i >= 0) && (inv[i] < 3) && (m_paid + ((i >= 0) ? val_idx(i) : 0) <= 15);
        coin_valid = 1'b1; coin = code;
        tick();
        coin_valid = 1'b0; coin = '0;
        if (acc) begin
            m_paid += val_idx(i);
            inv[i]++;
        end
        chk("coin.accept", coin_accept, acc);
        chk("coin.reject", coin_reject, !acc);
        chk("coin.paid", paid, m_paid);
        chk("coin.cough", cough_up_more, (m_paid < m_cost));
        chk_counts("coin");
    endtask

    task automatic restock(input logic [2:0] code);
        int i;
        i = idx_of(code);
        restock_valid = 1'b1; restock_coin = code;
        tick();
        restock_valid = 1'b0; restock_coin = '0;
        if (!m_busy && i >= 0 && inv[i] < 3) inv[i]++;
        chk_counts("restock");
    endtask

    task automatic finish_done();
        chk("done.txn_done", txn_done, 1);
        chk("done.disp_valid", disp_valid, 0);
        chk("done.disp_coin", disp_coin, 0);
        chk("done.exact", exact_amount, m_exact);
        chk("done.nec", not_enough_change, m_nec);
        chk("done.busy", busy, 1);
        chk_counts("done");
        tick();
        m_busy = 0;
        chk("idle.txn_done", txn_done, 0);
        chk("idle.busy", busy, 0);
        chk("idle.exact", exact_amount, m_exact);
        chk("idle.nec", not_enough_change, m_nec);
        chk("idle.paid", paid, m_paid);
    endtask

    // pay_done, then plan/dispense/done; optionally stop while the first coin is pending
    task automatic pay(input int stall_first, input bit rand_ready, input bit abort);
        int change, rem, stalls, i;
        int tmp[3];
        bit first, rdy;
        pay_done = 1'b1;
        tick();
        pay_done = 1'b0;
        if (m_paid < m_cost) begin
            chk("pay.short.busy", busy, 1);
            chk("pay.short.cough", cough_up_more, 1);
            chk("pay.short.disp_valid", disp_valid, 0);
            return;
        end
        chk("plan.cough", cough_up_more, 0);
        chk("plan.disp_valid", disp_valid, 0);
        chk("plan.txn_done", txn_done, 0);
        change = m_paid - m_cost;
        rem = change;
        tmp = inv;
        plan_q.delete();
        for (int d = 0; d < 3; d++) begin
            while (rem >= val_idx(d) && tmp[d] > 0) begin
                plan_q.push_back(code_idx(d));
                rem -= val_idx(d);
                tmp[d]--;
            end
        end
        tick();
        if (change == 0) begin
            m_exact = 1;
            finish_done();
        end else if (rem != 0) begin
            m_nec = 1;
            finish_done();
        end else begin
            first = 1;
            stalls = 0;
            while (plan_q.size() > 0) begin
                chk("disp.valid", disp_valid, 1);
                chk("disp.coin", disp_coin, plan_q[0]);
                chk("disp.txn_done", txn_done, 0);
                chk_counts("disp");
                if (abort) return;
                if (first && stalls < stall_first) rdy = 0;
                else if (rand_ready && stalls < 6) rdy = 1'($urandom_range(0, 1));
                else rdy = 1;
                disp_ready = rdy;
                tick();
                disp_ready = 1'b0;
                if (rdy) begin
                    i = idx_of(plan_q.pop_front());
                    inv[i]--;
                    first = 0;
                    stalls = 0;
                end else begin
                    stalls++;
                end
            end
            finish_done();
        end
    endtask

    initial begin
        reset_L = 1'b1;
        start = 0; coin_valid = 0; pay_done = 0; restock_valid = 0; disp_ready = 0;
        cost = '0; coin = '0; restock_coin = '0;
        #1;

        // cost 7, pay 5+3, one circle of change
        do_reset();
        start_txn(7);
        insert(3'b101);
        insert(3'b011);
        pay(0, 0, 0);
        chk("t1.cnt", {30'd0, pent_cnt, tri_cnt, cir_cnt}, {30'd0, 2'd3, 2'd3, 2'd1});

        // exact payment; flag sticky in IDLE until next start
        do_reset();
        start_txn(8);
        insert(3'b101);
        insert(3'b011);
        pay(0, 0, 0);
        tick();
        chk("t2.sticky", exact_amount, 1);
        start_txn(0);
        pay(0, 0, 0);

        // change 6 -> pentagon then circle, first coin stalled 3 cycles
        do_reset();
        start_txn(2);
        insert(3'b101);
        insert(3'b011);
        pay(3, 0, 0);

        // short payment, full pentagon slot, then exact
        do_reset();
        start_txn(9);
        insert(3'b011);
        pay(0, 0, 0);
        restock(3'b001);
        insert(3'b101);
        insert(3'b101);
        insert(3'b001);
        pay(0, 0, 0);

        // drain circles, then change of 1 cannot be made
        do_reset();
        start_txn(3);
        insert(3'b101);
        pay(0, 0, 0);
        start_txn(2);
        insert(3'b011);
        pay(0, 0, 0);
        chk("t5.nec", not_enough_change, 1);

        // reset with the first change coin pending
        do_reset();
        start_txn(2);
        insert(3'b101);
        insert(3'b011);
        pay(0, 0, 1);
        do_reset();
        tick();
        chk("t6.disp_valid", disp_valid, 0);
        restock(3'b011);
        chk("t6.tri", tri_cnt, 3);

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            int k;
            if ($urandom_range(0, 9) == 0) do_reset();
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) restock(rand_code());
            start_txn($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) restock(rand_code());
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) insert(rand_code());
            pay(int'($urandom_range(0, 2)), 1, 0);
            if (m_busy) do_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
